// File: rtl/zbb_pkg.sv
// Shared constants and bundle types for the Zbb decode/issue slice.
package zbb_pkg;

    localparam logic [4:0] ALU_NOP   = 5'b00000;
    localparam logic [4:0] ALU_CLZ   = 5'b00001;
    localparam logic [4:0] ALU_CTZ   = 5'b00010;
    localparam logic [4:0] ALU_CPOP  = 5'b00011;
    localparam logic [4:0] ALU_MINU  = 5'b00100;
    localparam logic [4:0] ALU_MAXU  = 5'b00101;
    localparam logic [4:0] ALU_SEXTH = 5'b00110;
    localparam logic [4:0] ALU_SEXTB = 5'b00111;
    localparam logic [4:0] ALU_MAX   = 5'b01000;
    localparam logic [4:0] ALU_MIN   = 5'b01001;
    localparam logic [4:0] ALU_ZEXTH = 5'b01010;
    localparam logic [4:0] ALU_ROL   = 5'b01011;
    localparam logic [4:0] ALU_ROR   = 5'b01100;
    localparam logic [4:0] ALU_ORCB  = 5'b01110;
    localparam logic [4:0] ALU_REV8  = 5'b01111;
    localparam logic [4:0] ALU_ANDN  = 5'b10000;
    localparam logic [4:0] ALU_ORN   = 5'b10001;
    localparam logic [4:0] ALU_XNOR  = 5'b10010;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;
    localparam logic [1:0] SEL_ZERO  = 2'b11;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_NEG  = 7'b0100000;
    localparam logic [6:0] F7_MMAX = 7'b0000101;
    localparam logic [6:0] F7_ROT  = 7'b0110000;
    localparam logic [6:0] F7_ZEXT = 7'b0000100;

    localparam logic [11:0] IMM_ORCB = 12'h287;
    localparam logic [11:0] IMM_REV8 = 12'h698;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
    } hist_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [4:0]  alu_op;
        logic [31:0] imm;
        logic [1:0]  mux1;
        logic [1:0]  mux2;
        logic        mux3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
    } id_ex_t;

    // Youngest producer wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input hist_t      h1,
        input hist_t      h2,
        input logic       en
    );
        if (rs == 5'd0)
            return SEL_ZERO;
        if (en && h1.v && h1.rd == rs)
            return SEL_EXMEM;
        if (en && h2.v && h2.rd == rs)
            return SEL_MEMWB;
        return SEL_RF;
    endfunction

endpackage

// File: rtl/zbb_decoder.sv
// Combinational Zbb instruction decoder.
module zbb_decoder
    import zbb_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  alu_op_o,
    output logic [31:0] imm_o,
    output logic        mux3_o,
    output logic        uses_rs2_o,
    output logic        reg_write_o,
    output logic        illegal_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs2;
    logic [11:0] imm12;
    logic        bin;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rs2   = instr_i[24:20];
    assign imm12 = instr_i[31:20];

    always_comb begin
        alu_op_o = ALU_NOP;
        imm_o    = '0;
        mux3_o   = 1'b0;
        bin      = 1'b0;
        case (opc)
            OPC_OP: begin
                bin = 1'b1;
                case (f7)
                    F7_NEG: begin
                        case (f3)
                            F3_AND:  alu_op_o = ALU_ANDN;
                            F3_OR:   alu_op_o = ALU_ORN;
                            F3_XOR:  alu_op_o = ALU_XNOR;
                            default: alu_op_o = ALU_NOP;
                        endcase
                    end
                    F7_MMAX: begin
                        case (f3)
                            F3_XOR:  alu_op_o = ALU_MIN;
                            F3_SRL:  alu_op_o = ALU_MINU;
                            F3_OR:   alu_op_o = ALU_MAX;
                            F3_AND:  alu_op_o = ALU_MAXU;
                            default: alu_op_o = ALU_NOP;
                        endcase
                    end
                    F7_ROT: begin
                        case (f3)
                            F3_SLL:  alu_op_o = ALU_ROL;
                            F3_SRL:  alu_op_o = ALU_ROR;
                            default: alu_op_o = ALU_NOP;
                        endcase
                    end
                    F7_ZEXT: begin
                        bin = 1'b0;
                        if (f3 == F3_XOR && rs2 == 5'd0)
                            alu_op_o = ALU_ZEXTH;
                    end
                    default: alu_op_o = ALU_NOP;
                endcase
            end
            OPC_OPIMM: begin
                if (f3 == F3_SLL && f7 == F7_ROT) begin
                    case (rs2)
                        5'd0:    alu_op_o = ALU_CLZ;
                        5'd1:    alu_op_o = ALU_CTZ;
                        5'd2:    alu_op_o = ALU_CPOP;
                        5'd4:    alu_op_o = ALU_SEXTB;
                        5'd5:    alu_op_o = ALU_SEXTH;
                        default: alu_op_o = ALU_NOP;
                    endcase
                end else if (f3 == F3_SRL) begin
                    if (f7 == F7_ROT) begin
                        alu_op_o = ALU_ROR;
                        mux3_o   = 1'b1;
                        imm_o    = {27'd0, rs2};
                    end else if (imm12 == IMM_ORCB) begin
                        alu_op_o = ALU_ORCB;
                    end else if (imm12 == IMM_REV8) begin
                        alu_op_o = ALU_REV8;
                    end
                end
            end
            default: alu_op_o = ALU_NOP;
        endcase
    end

    // Every legal encoding maps to a non-zero op code.
    assign illegal_o   = (alu_op_o == ALU_NOP);
    assign reg_write_o = ~illegal_o;
    assign uses_rs2_o  = bin & ~illegal_o;

endmodule

// File: rtl/zbb_issue_decode.sv
// Zbb decode/issue stage: ID/EX control register plus
// two-deep destination history for forwarding selects.
module zbb_issue_decode
    import zbb_pkg::*;
#(
    parameter bit FORWARD_EN           = 1'b1,
    parameter int RESET_PC_UNUSED_BITS = 0
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [4:0]  alu_op_o,
    output logic [31:0] imm_o,
    output logic [1:0]  mux1_o,
    output logic [1:0]  mux2_o,
    output logic        mux3_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_write_o,
    output logic        valid_o,
    output logic        illegal_o
);

    if (RESET_PC_UNUSED_BITS != 0) begin : g_bad_param
        $error("RESET_PC_UNUSED_BITS is reserved and must be 0");
    end

    logic [4:0]  dec_alu_op;
    logic [31:0] dec_imm;
    logic        dec_mux3;
    logic        dec_uses_rs2;
    logic        dec_reg_write;
    logic        dec_illegal;

    zbb_decoder u_dec (
        .instr_i     (instr_i),
        .alu_op_o    (dec_alu_op),
        .imm_o       (dec_imm),
        .mux3_o      (dec_mux3),
        .uses_rs2_o  (dec_uses_rs2),
        .reg_write_o (dec_reg_write),
        .illegal_o   (dec_illegal)
    );

    id_ex_t ctrl_d, ctrl_q;
    hist_t  h1_d, h1_q;
    hist_t  h2_d, h2_q;

    always_comb begin
        ctrl_d = ctrl_q;
        h1_d   = h1_q;
        h2_d   = h2_q;
        if (flush_i) begin
            ctrl_d = '0;
            h1_d   = '0;
            h2_d   = '0;
        end else if (!stall_i) begin
            ctrl_d = '0;
            if (instr_valid_i) begin
                ctrl_d.valid   = 1'b1;
                ctrl_d.illegal = dec_illegal;
                ctrl_d.rd      = instr_i[11:7];
                if (!dec_illegal) begin
                    ctrl_d.alu_op    = dec_alu_op;
                    ctrl_d.imm       = dec_imm;
                    ctrl_d.mux3      = dec_mux3;
                    ctrl_d.reg_write = dec_reg_write;
                    ctrl_d.rs1       = instr_i[19:15];
                    ctrl_d.rs2       = dec_uses_rs2 ? instr_i[24:20] : 5'd0;
                    ctrl_d.mux1      = fwd_sel(ctrl_d.rs1, h1_q, h2_q,
                                               FORWARD_EN);
                    ctrl_d.mux2      = dec_uses_rs2 ?
                                       fwd_sel(ctrl_d.rs2, h1_q, h2_q,
                                               FORWARD_EN) : SEL_RF;
                end
            end
            h2_d    = h1_q;
            h1_d.v  = ctrl_d.valid & ctrl_d.reg_write;
            h1_d.rd = ctrl_d.rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            h1_q   <= h1_d;
            h2_q   <= h2_d;
        end
    end

    assign instr_ready_o = ~stall_i;
    assign alu_op_o      = ctrl_q.alu_op;
    assign imm_o         = ctrl_q.imm;
    assign mux1_o        = ctrl_q.mux1;
    assign mux2_o        = ctrl_q.mux2;
    assign mux3_o        = ctrl_q.mux3;
    assign rs1_addr_o    = ctrl_q.rs1;
    assign rs2_addr_o    = ctrl_q.rs2;
    assign rd_addr_o     = ctrl_q.rd;
    assign reg_write_o   = ctrl_q.reg_write;
    assign valid_o       = ctrl_q.valid;
    assign illegal_o     = ctrl_q.illegal;

endmodule

// File: tb/tb_zbb_issue_decode.sv
// Directed bench for zbb_issue_decode, with a second
// instance built with forwarding disabled.
module tb_zbb_issue_decode;

    localparam logic [31:0] I_ANDN = 32'h4020F1B3;
    localparam logic [31:0] I_CLZ  = 32'h60019293;
    localparam logic [31:0] I_RORI = 32'h6072D313;
    localparam logic [31:0] I_REV8 = 32'h6980D393;
    localparam logic [31:0] I_ADD  = 32'h00000033;
    localparam logic [31:0] I_XNOR = 32'h40604433;
    localparam logic [31:0] I_MIN  = 32'h0A01C4B3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        valid_in;
    logic        stall;
    logic        flush;

    logic        ready, nf_ready;
    logic [4:0]  alu_op, nf_alu_op;
    logic [31:0] imm, nf_imm;
    logic [1:0]  mux1, nf_mux1;
    logic [1:0]  mux2, nf_mux2;
    logic        mux3, nf_mux3;
    logic [4:0]  rs1, nf_rs1;
    logic [4:0]  rs2, nf_rs2;
    logic [4:0]  rd, nf_rd;
    logic        rw, nf_rw;
    logic        vld, nf_vld;
    logic        ill, nf_ill;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zbb_issue_decode #(.FORWARD_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n_i       (rst_n),
        .instr_i       (instr),
        .instr_valid_i (valid_in),
        .instr_ready_o (ready),
        .stall_i       (stall),
        .flush_i       (flush),
        .alu_op_o      (alu_op),
        .imm_o         (imm),
        .mux1_o        (mux1),
        .mux2_o        (mux2),
        .mux3_o        (mux3),
        .rs1_addr_o    (rs1),
        .rs2_addr_o    (rs2),
        .rd_addr_o     (rd),
        .reg_write_o   (rw),
        .valid_o       (vld),
        .illegal_o     (ill)
    );

    zbb_issue_decode #(.FORWARD_EN(1'b0)) dut_nf (
        .clk           (clk),
        .rst_n_i       (rst_n),
        .instr_i       (instr),
        .instr_valid_i (valid_in),
        .instr_ready_o (nf_ready),
        .stall_i       (stall),
        .flush_i       (flush),
        .alu_op_o      (nf_alu_op),
        .imm_o         (nf_imm),
        .mux1_o        (nf_mux1),
        .mux2_o        (nf_mux2),
        .mux3_o        (nf_mux3),
        .rs1_addr_o    (nf_rs1),
        .rs2_addr_o    (nf_rs2),
        .rd_addr_o     (nf_rd),
        .reg_write_o   (nf_rw),
        .valid_o       (nf_vld),
        .illegal_o     (nf_ill)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins);
        instr    = ins;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        instr    = '0;
    endtask

    initial begin
        rst_n    = 1'b1;
        instr    = '0;
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, vld}, 32'd0);
        chk("rst_alu", {27'd0, alu_op}, 32'd0);
        step();
        step();
        chk("rst_imm", imm, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_mux", {28'd0, mux1, mux2}, 32'd0);
        chk("rst_rw_ill", {30'd0, rw, ill}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_valid", {31'd0, vld}, 32'd0);

        issue(I_ANDN);
        chk("andn_alu", {27'd0, alu_op}, 32'h10);
        chk("andn_rd", {27'd0, rd}, 32'd3);
        chk("andn_mux1", {30'd0, mux1}, 32'd0);
        chk("andn_mux2", {30'd0, mux2}, 32'd0);
        chk("andn_mux3", {31'd0, mux3}, 32'd0);
        chk("andn_rw", {31'd0, rw}, 32'd1);
        chk("andn_valid", {31'd0, vld}, 32'd1);
        chk("andn_rs", {22'd0, rs1, rs2}, {22'd0, 5'd1, 5'd2});
        chk("ready_idle", {31'd0, ready}, 32'd1);

        issue(I_CLZ);
        chk("clz_alu", {27'd0, alu_op}, 32'h01);
        chk("clz_mux1_h1", {30'd0, mux1}, 32'd2);
        chk("clz_mux2", {30'd0, mux2}, 32'd0);
        chk("clz_rs2", {27'd0, rs2}, 32'd0);
        chk("clz_rd", {27'd0, rd}, 32'd5);
        chk("nf_clz_mux1_h1", {30'd0, nf_mux1}, 32'd0);

        issue(I_ANDN);
        step();
        chk("bubble_valid", {31'd0, vld}, 32'd0);
        chk("bubble_rw", {31'd0, rw}, 32'd0);
        chk("bubble_alu", {27'd0, alu_op}, 32'd0);
        chk("bubble_mux", {28'd0, mux1, mux2}, 32'd0);
        issue(I_CLZ);
        chk("clz_mux1_h2", {30'd0, mux1}, 32'd1);
        chk("nf_clz_mux1_h2", {30'd0, nf_mux1}, 32'd0);

        issue(I_RORI);
        chk("rori_alu", {27'd0, alu_op}, 32'h0C);
        chk("rori_mux3", {31'd0, mux3}, 32'd1);
        chk("rori_imm", imm, 32'h7);
        chk("rori_mux1", {30'd0, mux1}, 32'd2);
        chk("rori_rd", {27'd0, rd}, 32'd6);

        issue(I_REV8);
        chk("rev8_alu", {27'd0, alu_op}, 32'h0F);
        chk("rev8_rd", {27'd0, rd}, 32'd7);
        chk("rev8_mux2", {30'd0, mux2}, 32'd0);
        chk("rev8_mux1", {30'd0, mux1}, 32'd0);
        chk("rev8_imm", imm, 32'd0);

        issue(I_ADD);
        chk("add_illegal", {31'd0, ill}, 32'd1);
        chk("add_valid", {31'd0, vld}, 32'd1);
        chk("add_rw", {31'd0, rw}, 32'd0);
        chk("add_alu", {27'd0, alu_op}, 32'd0);
        step();
        chk("add_ill_clear", {31'd0, ill}, 32'd0);

        issue(I_RORI);
        issue(I_XNOR);
        chk("xnor_alu", {27'd0, alu_op}, 32'h12);
        chk("xnor_mux1_x0", {30'd0, mux1}, 32'd3);
        chk("xnor_mux2_h1", {30'd0, mux2}, 32'd2);
        issue(I_MIN);
        chk("min_alu", {27'd0, alu_op}, 32'h09);
        chk("min_mux2_x0", {30'd0, mux2}, 32'd3);
        chk("min_rd", {27'd0, rd}, 32'd9);

        issue(I_ANDN);
        issue(I_ANDN);
        issue(I_CLZ);
        chk("h1_priority", {30'd0, mux1}, 32'd2);

        issue(I_ANDN);
        instr    = I_CLZ;
        valid_in = 1'b1;
        stall    = 1'b1;
        #1;
        chk("stall_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_alu", {27'd0, alu_op}, 32'h10);
            chk("stall_rd_vld", {26'd0, rd, vld}, {26'd0, 5'd3, 1'b1});
            chk("stall_ready_hold", {31'd0, ready}, 32'd0);
        end
        stall = 1'b0;
        step();
        valid_in = 1'b0;
        chk("post_stall_alu", {27'd0, alu_op}, 32'h01);
        chk("post_stall_mux1", {30'd0, mux1}, 32'd2);

        issue(I_ANDN);
        flush    = 1'b1;
        stall    = 1'b1;
        valid_in = 1'b1;
        instr    = I_CLZ;
        step();
        flush    = 1'b0;
        stall    = 1'b0;
        valid_in = 1'b0;
        chk("flush_valid", {31'd0, vld}, 32'd0);
        chk("flush_alu", {27'd0, alu_op}, 32'd0);
        issue(I_CLZ);
        chk("flush_clz_mux1", {30'd0, mux1}, 32'd0);
        chk("flush_clz_alu", {27'd0, alu_op}, 32'h01);

        issue(I_ANDN);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, vld}, 32'd0);
        chk("async_rst_alu", {27'd0, alu_op}, 32'd0);
        chk("async_rst_rd", {27'd0, rd}, 32'd0);
        rst_n = 1'b1;
        issue(I_CLZ);
        chk("post_rst_mux1", {30'd0, mux1}, 32'd0);
        chk("post_rst_valid", {31'd0, vld}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
